// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcodes
// and the select/op codes driven onto the datapath muxes.
package mc_pkg;

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_MEMADR = 4'd2,
      ST_MEMRD  = 4'd3,
      ST_MEMWB  = 4'd4,
      ST_MEMWR  = 4'd5,
      ST_EXEC   = 4'd6,
      ST_ALUWB  = 4'd7,
      ST_BRANCH = 4'd8,
      ST_JUMP   = 4'd9,
      ST_JAL    = 4'd10,
      ST_JR     = 4'd11,
      ST_LUI    = 4'd12,
      ST_IMMEX  = 4'd13,
      ST_IMMWB  = 4'd14,
      ST_FAULT  = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_JR    = 6'h08;

   localparam logic [1:0] PC_INC    = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;
   localparam logic [1:0] PC_RS     = 2'd3;

   localparam logic [1:0] DST_RT = 2'd0;
   localparam logic [1:0] DST_RD = 2'd1;
   localparam logic [1:0] DST_RA = 2'd2;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MDR = 2'd1;
   localparam logic [1:0] WB_PC  = 2'd2;
   localparam logic [1:0] WB_LUI = 2'd3;

   localparam logic [1:0] SRCB_RT     = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH = 2'd3;

   localparam logic [2:0] ALU_ADD   = 3'd0;
   localparam logic [2:0] ALU_SUB   = 3'd1;
   localparam logic [2:0] ALU_FUNCT = 3'd2;
   localparam logic [2:0] ALU_AND   = 3'd3;
   localparam logic [2:0] ALU_OR    = 3'd4;
   localparam logic [2:0] ALU_SLT   = 3'd5;

   function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
      case (op)
         OP_ANDI: imm_alu_op = ALU_AND;
         OP_ORI:  imm_alu_op = ALU_OR;
         OP_SLTI: imm_alu_op = ALU_SLT;
         default: imm_alu_op = ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/mc_opcode_decode.sv
// Dispatch table: selects the state that follows DECODE for an opcode/funct
// pair and flags encodings the control path does not implement.
module mc_opcode_decode
   import mc_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output state_t     next_state,
   output logic       illegal
);

   always_comb begin
      next_state = ST_FAULT;
      illegal    = 1'b0;
      case (opcode)
         OP_LW, OP_SW:                    next_state = ST_MEMADR;
         OP_RTYPE:                        next_state = (funct == FN_JR) ? ST_JR : ST_EXEC;
         OP_BEQ, OP_BNE:                  next_state = ST_BRANCH;
         OP_J:                            next_state = ST_JUMP;
         OP_JAL:                          next_state = ST_JAL;
         OP_LUI:                          next_state = ST_LUI;
         OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = ST_IMMEX;
         default:                         illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM over a shared ready/valid memory port, with
// a memory-wait timeout fault and a retired-instruction counter.
module multicycle_control
   import mc_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             alu_zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             iord,
   output logic             ir_write,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             reg_write,
   output logic [1:0]       reg_dst,
   output logic [1:0]       mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_op,
   output logic             fault,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instret
);

   localparam int TW = $clog2(MEM_TIMEOUT);
   localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

   state_t        cur;
   state_t        nxt;
   state_t        dec_next;
   logic          dec_illegal;
   logic [TW-1:0] tmo_cnt;
   logic          waiting;
   logic          tmo_hit;
   logic          retire;

   mc_opcode_decode u_decode (
      .opcode     (opcode),
      .funct      (funct),
      .next_state (dec_next),
      .illegal    (dec_illegal)
   );

   assign waiting = (cur == ST_FETCH) || (cur == ST_MEMRD) || (cur == ST_MEMWR);
   // mem_ready in the final allowed cycle still completes normally.
   assign tmo_hit = waiting && !mem_ready && (tmo_cnt == TMO_LAST);

   always_comb begin
      nxt    = cur;
      retire = 1'b0;
      case (cur)
         ST_FETCH:  if (mem_ready) nxt = ST_DECODE; else if (tmo_hit) nxt = ST_FAULT;
         ST_DECODE: nxt = dec_illegal ? ST_FAULT : dec_next;
         ST_MEMADR: nxt = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
         ST_MEMRD:  if (mem_ready) nxt = ST_MEMWB; else if (tmo_hit) nxt = ST_FAULT;
         ST_MEMWR: begin
            if (mem_ready) begin
               nxt    = ST_FETCH;
               retire = 1'b1;
            end else if (tmo_hit) begin
               nxt = ST_FAULT;
            end
         end
         ST_EXEC:   nxt = ST_ALUWB;
         ST_IMMEX:  nxt = ST_IMMWB;
         ST_FAULT:  nxt = ST_FAULT;
         default: begin
            nxt    = ST_FETCH;
            retire = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur     <= ST_FETCH;
         tmo_cnt <= '0;
         instret <= '0;
      end else begin
         cur <= nxt;
         if (waiting && !mem_ready && (nxt == cur))
            tmo_cnt <= tmo_cnt + TW'(1);
         else
            tmo_cnt <= '0;
         if (retire)
            instret <= instret + CNT_W'(1);
      end
   end

   assign state = cur;

   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PC_INC;
      reg_write  = 1'b0;
      reg_dst    = DST_RT;
      mem_to_reg = WB_ALU;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_RT;
      alu_op     = ALU_ADD;
      fault      = 1'b0;
      if (rst) begin
         case (cur)
            ST_FETCH: begin
               mem_req   = 1'b1;
               alu_src_b = SRCB_FOUR;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            ST_DECODE: alu_src_b = SRCB_IMM_SH;
            ST_MEMADR: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_IMM;
            end
            ST_MEMRD: begin
               mem_req = 1'b1;
               iord    = 1'b1;
            end
            ST_MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = WB_MDR;
            end
            ST_MEMWR: begin
               mem_req = 1'b1;
               mem_we  = 1'b1;
               iord    = 1'b1;
            end
            ST_EXEC: begin
               alu_src_a = 1'b1;
               alu_op    = ALU_FUNCT;
            end
            ST_ALUWB: begin
               reg_write = 1'b1;
               reg_dst   = DST_RD;
            end
            ST_BRANCH: begin
               alu_src_a = 1'b1;
               alu_op    = ALU_SUB;
               pc_src    = PC_BRANCH;
               pc_write  = (opcode == OP_BEQ) ? alu_zero : !alu_zero;
            end
            ST_JUMP: begin
               pc_write = 1'b1;
               pc_src   = PC_JUMP;
            end
            ST_JAL: begin
               reg_write  = 1'b1;
               reg_dst    = DST_RA;
               mem_to_reg = WB_PC;
               pc_write   = 1'b1;
               pc_src     = PC_JUMP;
            end
            ST_JR: begin
               pc_write = 1'b1;
               pc_src   = PC_RS;
            end
            ST_LUI: begin
               reg_write  = 1'b1;
               mem_to_reg = WB_LUI;
            end
            ST_IMMEX: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_IMM;
               alu_op    = imm_alu_op(opcode);
            end
            ST_IMMWB:  reg_write = 1'b1;
            ST_FAULT:  fault = 1'b1;
            default: ;
         endcase
      end
   end

endmodule
